// File: rtl/bcd8_to_bin.sv
// Sequential packed-BCD to binary converter: one digit per clock, MSB digit first,
// with start/done handshake, sticky saturation and invalid-digit flag.
module bcd8_to_bin #(
  parameter int DIGITS = 8,
  parameter int OUT_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      bin_out,
  output logic                  overflow,
  output logic                  digit_err
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int T_W   = OUT_W + 4;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [OUT_W-1:0] MAX_VAL = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OUT_W-1:0] bin_out_q, bin_out_d;
  logic             overflow_q, overflow_d;
  logic             digit_err_q, digit_err_d;
  logic             done_q, done_d;

  logic [3:0]       top_nib;
  logic             top_bad;
  logic [T_W-1:0]   step_t;
  logic             step_ovf;

  function automatic logic [3:0] digit_val(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  function automatic logic [T_W-1:0] mac10(input logic [OUT_W-1:0] acc,
                                           input logic [3:0]       d);
    return ({4'b0000, acc} * T_W'(10)) + T_W'(d);
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic [T_W-1:0] t,
                                                input logic           ovf);
    return ovf ? MAX_VAL : t[OUT_W-1:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CONV;
      S_CONV: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    if (state_q == S_CONV) busy = 1'b1;
  end

  assign top_nib  = sr_q[SR_W-1 -: 4];
  assign top_bad  = (top_nib > 4'd9);
  assign step_t   = mac10(acc_q, digit_val(top_nib));
  // Once saturated, later digits cannot bring the result back below the maximum.
  assign step_ovf = ovf_q | (step_t > T_W'(MAX_VAL));

  always_comb begin
    sr_d        = sr_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    bin_out_d   = bin_out_q;
    overflow_d  = overflow_q;
    digit_err_d = digit_err_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d  = bcd_in;
          acc_d = '0;
          ovf_d = 1'b0;
          err_d = 1'b0;
          cnt_d = CNT_W'(DIGITS);
        end
      end
      S_CONV: begin
        sr_d  = {sr_q[SR_W-5:0], 4'b0000};
        err_d = err_q | top_bad;
        ovf_d = step_ovf;
        acc_d = saturate(step_t, step_ovf);
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        bin_out_d   = acc_q;
        overflow_d  = ovf_q;
        digit_err_d = err_q;
        done_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q        <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      bin_out_q   <= '0;
      overflow_q  <= 1'b0;
      digit_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      bin_out_q   <= bin_out_d;
      overflow_q  <= overflow_d;
      digit_err_q <= digit_err_d;
      done_q      <= done_d;
    end
  end

  assign done      = done_q;
  assign bin_out   = bin_out_q;
  assign overflow  = overflow_q;
  assign digit_err = digit_err_q;

endmodule

// File: doc/bcd8_to_bin.md
# bcd8_to_bin

Sequential BCD-to-binary converter for the sound monitor. It takes an 8-digit packed BCD word, such as a threshold entered digit-by-digit on the board switches or keypad, and produces the binary value used by the level-comparison logic. It is the inverse of the display path's binary-to-BCD digit split. The result is built MSB digit first, one digit per clock, with a start/done handshake, saturation and input-error flags.

## Interface
- DIGITS, 8, number of packed BCD digits in `bcd_in`.
- OUT_W, 11, binary result width; matches the 11-bit level bus.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; [3:0] = ones digit, [4*DIGITS-1:4*DIGITS-4] = most significant digit.
- busy  output  1  high while a conversion is in progress (CONV state).
- done  output  1  one-cycle pulse; `bin_out` and flags valid from this cycle.
- bin_out  output  OUT_W  converted value; holds until the next `done`.
- overflow  output  1  value exceeded 2^OUT_W-1; `bin_out` saturated.
- digit_err  output  1  at least one input nibble was greater than 9.

## Operation
- FSM states: IDLE, CONV, DONE.
  - IDLE: on `start`=1, latch `bcd_in` into the digit shift register, clear acc, ovf and err, load digit counter = DIGITS, go to CONV.
  - CONV: each cycle, consume the top nibble d and shift the register left by 4.
    - If d > 9: set err and use 0 as the digit value.
    - Compute t = acc*10 + d at OUT_W+4 bits.
    - If t > 2^OUT_W-1, or ovf is already set: acc <= 2^OUT_W-1 and ovf <= 1. Otherwise acc <= t[OUT_W-1:0].
    - Decrement the counter. After the last digit, go to DONE.
  - DONE: register acc into `bin_out`, ovf into `overflow`, err into `digit_err`; pulse `done`; return to IDLE.
- `start` is ignored in CONV and DONE (no queueing). `bcd_in` may change freely after the start cycle.
- Saturation is sticky within a conversion: once set, the result stays at the maximum.
- `bin_out`, `overflow` and `digit_err` change only in DONE.

## Timing
- Reset (rst=0, asynchronous): state IDLE, `busy`=0, `done`=0, `bin_out`=0, `overflow`=0, `digit_err`=0, internal acc, shift register and counter cleared.
- Release is synchronous to clk; the first `start` is accepted on the first rising edge with rst=1.
- `start` sampled at edge E0:
  - `busy`=1 from E0 through E0+DIGITS (DIGITS cycles).
  - `done`=1 for exactly one cycle after edge E0+DIGITS+1, with outputs updated at that same edge.
- Latency from start edge to results: DIGITS+1 cycles (9 at default).
- Minimum start-to-start spacing: DIGITS+2 cycles. A `start` held high continuously re-triggers at exactly that spacing.
- Reset asserted mid-conversion aborts it immediately. No `done` pulse is produced and outputs return to reset values.
- Outputs are registered; there is no combinational path from `start` or `bcd_in` to any output.

## Test plan
- Reset, then `bcd_in`=0x00001234 with a 1-cycle `start` -> `busy` high 8 cycles, `done` at start+9, `bin_out`=1234, `overflow`=0, `digit_err`=0.
- `bcd_in`=0x00002047 -> `bin_out`=2047, no flags. `bcd_in`=0x00002048 -> `bin_out`=2047, `overflow`=1. `bcd_in`=0x99999999 -> `bin_out`=2047, `overflow`=1.
- `bcd_in`=0x000001A5 -> `bin_out`=105 ('A' counted as 0), `digit_err`=1, `overflow`=0. Next conversion of 0x00000007 -> 7 with both flags cleared.
- `start` pulsed again at start+3 and start+9 with different data -> ignored. Only the first result appears, and the next `start` is accepted in IDLE at start+10.
- Deassert rst at start+4 of a 0x00000999 conversion -> all outputs 0 immediately, no `done`. After release, a new conversion of 0x00000042 -> 42.
- Sweep 0..2047, each value encoded as packed BCD, back-to-back at 10-cycle spacing -> `bin_out` equals the value each time, with zero flags.
